// File: rtl/fu_wb_pkg.sv
// fu_wb_pkg: shared constants and the writeback entry layout for fu_wb_buffer
package fu_wb_pkg;
  localparam int DEPTH_DEF  = 4;
  localparam int NOUT_DEF   = 3;
  localparam int DATA_W_DEF = 64;
  localparam int PRN_W_DEF  = 7;
  localparam int ID_W_DEF   = 6;
  localparam int FLAG_SLOT  = 2;
  typedef struct packed {
    logic [ID_W_DEF-1:0]                  inst_id;
    logic [NOUT_DEF-1:0][PRN_W_DEF-1:0]   prn;
    logic [NOUT_DEF-1:0][DATA_W_DEF-1:0]  data;
    logic [NOUT_DEF-1:0]                  data_valid;
  } wb_entry_t;
endpackage

// File: rtl/fu_wb_fifo.sv
// fu_wb_fifo: DEPTH-entry FIFO storage with wrapping pointers and occupancy count
// Ports: push/wdata write at the tail, pop retires the head shown on rdata,
// count is current occupancy, full/empty decode it. Callers must not push
// when full without a pop, nor pop when empty.
module fu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/fu_wb_buffer.sv
// fu_wb_buffer: buffers FU results and drains them to writeback with a valid/ready handshake
// Inputs in_* carry one registered FU result per cycle; wb_* present the FIFO head
// to the writeback arbiter; fu_ready is the issue credit; count is occupancy;
// overflow_err is sticky when a result had to be dropped.
// Define FU_WB_BYPASS_EN to let a result reach wb_* in its arrival cycle when empty.
module fu_wb_buffer import fu_wb_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NOUT   = NOUT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PRN_W  = PRN_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ID_W-1:0]          in_inst_id,
  input  logic [NOUT*PRN_W-1:0]    in_prn,
  input  logic [NOUT*DATA_W-1:0]   in_data,
  input  logic [NOUT-1:0]          in_data_valid,
  output logic                     fu_ready,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ID_W-1:0]          wb_inst_id,
  output logic [NOUT*PRN_W-1:0]    wb_prn,
  output logic [NOUT*DATA_W-1:0]   wb_data,
  output logic [NOUT-1:0]          wb_data_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int W  = ID_W + NOUT * (PRN_W + DATA_W + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH - 1);
  logic [W-1:0] in_e, head, out_e;
  logic         push, pop, full, empty, ovf_q, ovf_d;
  logic [CW:0]  need;
  assign in_e = {in_inst_id, in_prn, in_data, in_data_valid};
  fu_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    pop  = !rst && !empty && wb_ready;
    need = {1'b0, count} + (CW+1)'(in_valid);
    // pops are not credited so the credit depends only on count and in_valid
    fu_ready = !rst && need <= LIM;
    ovf_d    = ovf_q | (in_valid && full && !pop);
`ifdef FU_WB_BYPASS_EN
    wb_valid = !rst && (!empty || in_valid);
    out_e    = empty ? in_e : head;
    // a bypassed result accepted in its arrival cycle never occupies a slot
    push     = in_valid && (!full || pop) && !(empty && wb_ready);
`else
    wb_valid = !rst && !empty;
    out_e    = head;
    push     = in_valid && (!full || pop);
`endif
  end
  always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
  assign {wb_inst_id, wb_prn, wb_data, wb_data_valid} = out_e;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_fu_wb_buffer.sv
// tb_fu_wb_buffer: table-driven directed checks of fu_wb_buffer plus corner-case sequences
module tb_fu_wb_buffer;
`ifdef FU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic         clk, rst, in_valid, wb_ready, fu_ready, wb_valid, overflow_err;
  logic [5:0]   in_inst_id, wb_inst_id;
  logic [20:0]  in_prn, wb_prn;
  logic [191:0] in_data, wb_data;
  logic [2:0]   in_data_valid, wb_data_valid, count;
  int tests = 0, fails = 0;
  fu_wb_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_inst_id    (in_inst_id),
    .in_prn        (in_prn),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .fu_ready      (fu_ready),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_inst_id    (wb_inst_id),
    .wb_prn        (wb_prn),
    .wb_data       (wb_data),
    .wb_data_valid (wb_data_valid),
    .count         (count),
    .overflow_err  (overflow_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic       rst, iv;
    logic [5:0] id;
    logic       wr, ewv;
    logic [5:0] eid;
    logic [2:0] ecnt;
    logic       efr, eovf;
  } vec_t;
  vec_t tbl[22];
  function automatic vec_t v(input logic r, iv, input logic [5:0] id, input logic wr, ewv,
                             input logic [5:0] eid, input logic [2:0] ec, input logic efr, eovf);
    vec_t t;
    t.rst = r; t.iv = iv; t.id = id; t.wr = wr; t.ewv = ewv;
    t.eid = eid; t.ecnt = ec; t.efr = efr; t.eovf = eovf;
    return t;
  endfunction
  function automatic logic [63:0] dat(input logic [5:0] id);
    return (id == 6'd5) ? 64'h10 : {58'd0, id};
  endfunction
  function automatic logic [2:0] dvf(input logic [5:0] id);
    return (id == 6'd5) ? 3'b101 : 3'b111;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, iv, input logic [5:0] id, input logic wr);
    rst = r; in_valid = iv; in_inst_id = id; wb_ready = wr;
    in_data = {128'd0, dat(id)};
    in_data_valid = dvf(id);
    in_prn = {3{{1'b0, id}}};
  endtask
  initial begin
    logic       ewv, byp;
    logic [5:0] eid;
    tbl[0]  = v(1, 1, 9,  0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 5,  0, 0, 0, 0, 1, 0);
    tbl[2]  = v(0, 0, 0,  1, 1, 5, 1, 1, 0);
    tbl[3]  = v(0, 0, 0,  0, 0, 0, 0, 1, 0);
    tbl[4]  = v(0, 1, 1,  0, 0, 0, 0, 1, 0);
    tbl[5]  = v(0, 1, 2,  0, 1, 1, 1, 1, 0);
    tbl[6]  = v(0, 1, 3,  0, 1, 1, 2, 1, 0);
    tbl[7]  = v(0, 1, 4,  0, 1, 1, 3, 0, 0);
    tbl[8]  = v(0, 0, 0,  0, 1, 1, 4, 0, 0);
    tbl[9]  = v(0, 1, 7,  0, 1, 1, 4, 0, 0);
    tbl[10] = v(0, 0, 0,  0, 1, 1, 4, 0, 1);
    tbl[11] = v(0, 1, 8,  1, 1, 1, 4, 0, 1);
    tbl[12] = v(0, 0, 0,  1, 1, 2, 4, 0, 1);
    tbl[13] = v(0, 0, 0,  1, 1, 3, 3, 1, 1);
    tbl[14] = v(0, 0, 0,  1, 1, 4, 2, 1, 1);
    tbl[15] = v(0, 0, 0,  1, 1, 8, 1, 1, 1);
    tbl[16] = v(0, 0, 0,  0, 0, 0, 0, 1, 1);
    tbl[17] = v(0, 1, 10, 0, 0, 0, 0, 1, 1);
    tbl[18] = v(0, 1, 11, 0, 1, 10, 1, 1, 1);
    tbl[19] = v(0, 1, 12, 0, 1, 10, 2, 1, 1);
    tbl[20] = v(1, 1, 13, 0, 0, 0, 3, 0, 1);
    tbl[21] = v(0, 0, 0,  0, 0, 0, 0, 1, 0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].wr);
      #1;
      byp = BYP && tbl[i].ecnt == 3'd0 && tbl[i].iv && !tbl[i].rst;
      ewv = tbl[i].ewv | byp;
      eid = byp ? tbl[i].id : tbl[i].eid;
      chk($sformatf("row%0d wb_valid", i), 64'(wb_valid), 64'(ewv));
      chk($sformatf("row%0d count", i), 64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("row%0d fu_ready", i), 64'(fu_ready), 64'(tbl[i].efr));
      chk($sformatf("row%0d overflow_err", i), 64'(overflow_err), 64'(tbl[i].eovf));
      if (ewv) begin
        chk($sformatf("row%0d wb_inst_id", i), 64'(wb_inst_id), 64'(eid));
        chk($sformatf("row%0d wb_data0", i), wb_data[63:0], dat(eid));
        chk($sformatf("row%0d wb_data_valid", i), 64'(wb_data_valid), 64'(dvf(eid)));
        chk($sformatf("row%0d wb_prn0", i), 64'(wb_prn[6:0]), 64'(eid));
      end
    end
    @(negedge clk);
    drive(0, 1, 20, 0);
    in_data = {64'h6, 128'd0};
    in_data_valid = 3'b100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      #1;
      chk($sformatf("cmp hold%0d wb_valid", c), 64'(wb_valid), 64'd1);
      chk($sformatf("cmp hold%0d wb_inst_id", c), 64'(wb_inst_id), 64'd20);
      chk($sformatf("cmp hold%0d wb_data_valid", c), 64'(wb_data_valid), 64'(3'b100));
      chk($sformatf("cmp hold%0d wb_data2", c), wb_data[191:128], 64'h6);
      chk($sformatf("cmp hold%0d count", c), 64'(count), 64'd1);
    end
    @(negedge clk);
    wb_ready = 1'b1;
    #1;
    chk("cmp drain wb_inst_id", 64'(wb_inst_id), 64'd20);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("cmp drained count", 64'(count), 64'd0);
    chk("cmp drained wb_valid", 64'(wb_valid), 64'd0);
    @(negedge clk);
    drive(0, 1, 30, 1);
    #1;
    chk("latency same-cycle wb_valid", 64'(wb_valid), 64'(BYP));
    @(negedge clk);
    drive(0, 0, 0, 1);
    #1;
    chk("latency next count", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("latency next wb_valid", 64'(wb_valid), BYP ? 64'd0 : 64'd1);
    if (!BYP) chk("latency next wb_inst_id", 64'(wb_inst_id), 64'd30);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("final count", 64'(count), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
